// File: rtl/fetch_pc_ctrl.sv
// Program-counter, next-PC selection and processor status for the sequential Y86-64 core.
// The PC is presented to instruction memory; decoded fields come back in the same cycle.
module fetch_pc_ctrl #(
   parameter int                  DATA_WID = 64,
   parameter logic [DATA_WID-1:0] RESET_PC = '0,
   parameter int                  MEM_SIZE = 2048
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic [3:0]          icode,
   input  logic [3:0]          ifun,
   input  logic [DATA_WID-1:0] valC,
   input  logic                Cnd,
   input  logic [DATA_WID-1:0] valM,
   input  logic                mem_err,
   output logic [DATA_WID-1:0] PC,
   output logic [DATA_WID-1:0] valP,
   output logic [2:0]          stat,
   output logic                halted,
   output logic [31:0]         retired
);

   typedef enum logic [2:0] {
      S_AOK = 3'd1,
      S_HLT = 3'd2,
      S_ADR = 3'd3,
      S_INS = 3'd4
   } stat_t;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [DATA_WID:0] MEM_LIMIT = (DATA_WID+1)'(MEM_SIZE);

   stat_t               stat_q;
   logic [DATA_WID-1:0] pc_q;
   logic [3:0]          ilen;
   logic                instr_valid;
   logic [DATA_WID:0]   fetch_end;
   logic                fetch_adr_err;
   logic [DATA_WID-1:0] next_pc;

   always_comb begin
      ilen = 4'd1;
      unique case (icode)
         I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: ilen = 4'd2;
         I_JXX, I_CALL:                    ilen = 4'd9;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     ilen = 4'd10;
         default:                          ilen = 4'd1;
      endcase
   end

   always_comb begin
      instr_valid = 1'b0;
      unique case (icode)
         I_RRMOVQ, I_JXX:                      instr_valid = (ifun <= 4'd6);
         I_OPQ:                                instr_valid = (ifun <= 4'd3);
         I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ,
         I_MRMOVQ, I_CALL, I_RET, I_PUSHQ,
         I_POPQ:                               instr_valid = (ifun == 4'd0);
         default:                              instr_valid = 1'b0;
      endcase
   end

   assign valP = pc_q + DATA_WID'(ilen);

   // One extra bit so an instruction straddling the top of the address space still flags.
   assign fetch_end     = {1'b0, pc_q} + (DATA_WID+1)'(ilen);
   assign fetch_adr_err = (fetch_end > MEM_LIMIT);

   always_comb begin
      next_pc = valP;
      unique case (icode)
         I_JXX:   next_pc = Cnd ? valC : valP;
         I_CALL:  next_pc = valC;
         I_RET:   next_pc = valM;
         default: next_pc = valP;
      endcase
   end

   // Error states are absorbing: only the asynchronous reset brings the core back to AOK.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         stat_q  <= S_AOK;
         halted  <= 1'b0;
         retired <= '0;
      end else if (!stall && stat_q == S_AOK) begin
         if (!instr_valid) begin
            stat_q <= S_INS;
            halted <= 1'b1;
         end else if (fetch_adr_err || mem_err) begin
            stat_q <= S_ADR;
            halted <= 1'b1;
         end else if (icode == I_HALT) begin
            stat_q  <= S_HLT;
            halted  <= 1'b1;
            retired <= (retired == 32'hFFFF_FFFF) ? retired : retired + 32'd1;
         end else begin
            pc_q    <= next_pc;
            retired <= (retired == 32'hFFFF_FFFF) ? retired : retired + 32'd1;
         end
      end
   end

   assign PC   = pc_q;
   assign stat = stat_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Table-driven bench for fetch_pc_ctrl: vector table for the main run plus hand sequences
// for errors, halt absorption, stall, saturation and asynchronous reset.
module tb_fetch_pc_ctrl;

   localparam int SW = 64 + 3 + 1 + 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic [3:0]  icode = 4'h1;
   logic [3:0]  ifun = 4'h0;
   logic [63:0] valC = '0;
   logic        Cnd = 1'b0;
   logic [63:0] valM = '0;
   logic        mem_err = 1'b0;
   logic [63:0] PC;
   logic [63:0] valP;
   logic [2:0]  stat;
   logic        halted;
   logic [31:0] retired;

   int n_checks = 0;
   int n_errors = 0;
   logic [SW-1:0] exp_q[$];

   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] valc;
      logic        cnd;
      logic [63:0] valm;
      logic        mem_err;
      logic        stall;
      logic [63:0] exp_valp;
      logic [63:0] exp_pc;
      logic [2:0]  exp_stat;
      logic [31:0] exp_ret;
   } vec_t;

   vec_t tbl[16];

   fetch_pc_ctrl #(.DATA_WID(64), .RESET_PC(64'h0), .MEM_SIZE(2048)) dut (
      .clk(clk), .rst(rst), .stall(stall), .icode(icode), .ifun(ifun), .valC(valC),
      .Cnd(Cnd), .valM(valM), .mem_err(mem_err), .PC(PC), .valP(valP), .stat(stat),
      .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] vc, input logic cd, input logic [63:0] vm,
                               input logic me, input logic st, input logic [63:0] vp,
                               input logic [63:0] pc, input logic [2:0] sa, input logic [31:0] rt);
      vec_t v;
      v.icode = ic; v.ifun = fn; v.valc = vc; v.cnd = cd; v.valm = vm; v.mem_err = me;
      v.stall = st; v.exp_valp = vp; v.exp_pc = pc; v.exp_stat = sa; v.exp_ret = rt;
      return v;
   endfunction

   function automatic logic [SW-1:0] pack(input logic [63:0] pc, input logic [2:0] sa,
                                          input logic [31:0] rt);
      return {pc, sa, (sa != 3'd1), rt};
   endfunction

   task automatic compare_state(input string name, input logic [SW-1:0] exp);
      logic [SW-1:0] act;
      act = {PC, stat, halted, retired};
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got pc=%h stat=%0d halted=%0b retired=%h, expected pc=%h stat=%0d halted=%0b retired=%h",
                  name, PC, stat, halted, retired, exp[SW-1 -: 64], exp[35:33], exp[32], exp[31:0]);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      stall = 1'b0; icode = 4'h1; ifun = 4'h0; valC = '0; Cnd = 1'b0; valM = '0; mem_err = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input string name, input vec_t v);
      icode = v.icode; ifun = v.ifun; valC = v.valc; Cnd = v.cnd; valM = v.valm;
      mem_err = v.mem_err; stall = v.stall;
      #1;
      n_checks++;
      if (valP !== v.exp_valp) begin
         n_errors++;
         $display("FAIL %s valP: got %h, expected %h", name, valP, v.exp_valp);
      end
      exp_q.push_back(pack(v.exp_pc, v.exp_stat, v.exp_ret));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++; n_errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         compare_state(name, exp_q.pop_front());
      end
      @(negedge clk);
   endtask

   initial begin
      // icode ifun valC Cnd valM mem_err stall | valP PC stat retired
      tbl[0]  = mk(4'h1, 4'h0, 64'h0,   1'b0, 64'h0, 1'b0, 1'b0, 64'h01,  64'h01,  3'd1, 32'd1);
      tbl[1]  = mk(4'h3, 4'h0, 64'h55,  1'b0, 64'h0, 1'b0, 1'b0, 64'h0B,  64'h0B,  3'd1, 32'd2);
      tbl[2]  = mk(4'h7, 4'h0, 64'h40,  1'b0, 64'h0, 1'b0, 1'b0, 64'h14,  64'h14,  3'd1, 32'd3);
      tbl[3]  = mk(4'h7, 4'h0, 64'h40,  1'b1, 64'h0, 1'b0, 1'b0, 64'h1D,  64'h40,  3'd1, 32'd4);
      tbl[4]  = mk(4'h8, 4'h0, 64'h100, 1'b0, 64'h0, 1'b0, 1'b0, 64'h49,  64'h100, 3'd1, 32'd5);
      tbl[5]  = mk(4'h9, 4'h0, 64'h0,   1'b0, 64'h9, 1'b0, 1'b0, 64'h101, 64'h09,  3'd1, 32'd6);
      tbl[6]  = mk(4'h1, 4'h0, 64'h0,   1'b0, 64'h0, 1'b0, 1'b1, 64'h0A,  64'h09,  3'd1, 32'd6);
      tbl[7]  = mk(4'h1, 4'h0, 64'h0,   1'b0, 64'h0, 1'b0, 1'b1, 64'h0A,  64'h09,  3'd1, 32'd6);
      tbl[8]  = mk(4'h1, 4'h0, 64'h0,   1'b0, 64'h0, 1'b0, 1'b1, 64'h0A,  64'h09,  3'd1, 32'd6);
      tbl[9]  = mk(4'hC, 4'h0, 64'h0,   1'b0, 64'h0, 1'b1, 1'b1, 64'h0A,  64'h09,  3'd1, 32'd6);
      tbl[10] = mk(4'h6, 4'h3, 64'h0,   1'b0, 64'h0, 1'b0, 1'b0, 64'h0B,  64'h0B,  3'd1, 32'd7);
      tbl[11] = mk(4'h2, 4'h6, 64'h0,   1'b0, 64'h0, 1'b0, 1'b0, 64'h0D,  64'h0D,  3'd1, 32'd8);
      tbl[12] = mk(4'hA, 4'h0, 64'h0,   1'b0, 64'h0, 1'b0, 1'b0, 64'h0F,  64'h0F,  3'd1, 32'd9);
      tbl[13] = mk(4'h5, 4'h0, 64'h0,   1'b0, 64'h0, 1'b0, 1'b0, 64'h19,  64'h19,  3'd1, 32'd10);
      tbl[14] = mk(4'h7, 4'h6, 64'h20,  1'b1, 64'h0, 1'b0, 1'b0, 64'h22,  64'h20,  3'd1, 32'd11);
      tbl[15] = mk(4'h0, 4'h0, 64'h0,   1'b0, 64'h0, 1'b0, 1'b0, 64'h21,  64'h20,  3'd2, 32'd12);

      reset_dut();
      #1;
      compare_state("reset_values", pack(64'h0, 3'd1, 32'd0));
      for (int i = 0; i < 16; i++) step($sformatf("vec%0d", i), tbl[i]);

      // Halt is absorbing.
      for (int i = 0; i < 10; i++) begin
         icode = 4'($urandom_range(0, 15)); ifun = 4'($urandom_range(0, 15));
         valC = {32'($urandom), 32'($urandom)}; valM = {32'($urandom), 32'($urandom)};
         Cnd = 1'($urandom_range(0, 1)); mem_err = 1'($urandom_range(0, 1));
         stall = 1'($urandom_range(0, 1));
         exp_q.push_back(pack(64'h20, 3'd2, 32'd12));
         @(posedge clk);
         #1;
         compare_state($sformatf("halt_hold%0d", i), exp_q.pop_front());
         @(negedge clk);
      end

      // Invalid icode, then asynchronous reset out of INS between edges.
      reset_dut();
      step("nop0", mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 64'd1, 64'd1, 3'd1, 32'd1));
      step("nop1", mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 64'd2, 64'd2, 3'd1, 32'd2));
      step("icode_c", mk(4'hC, 4'h0, 0, 0, 0, 0, 0, 64'd3, 64'd2, 3'd4, 32'd2));
      step("ins_hold", mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 64'd3, 64'd2, 3'd4, 32'd2));
      #2;
      rst = 1'b1;
      #1;
      compare_state("async_reset", pack(64'h0, 3'd1, 32'd0));
      @(negedge clk);
      rst = 1'b0;

      reset_dut();
      step("opq_ifun4", mk(4'h6, 4'h4, 0, 0, 0, 0, 0, 64'd2, 64'd0, 3'd4, 32'd0));
      reset_dut();
      step("rrmov_ifun7", mk(4'h2, 4'h7, 0, 0, 0, 0, 0, 64'd2, 64'd0, 3'd4, 32'd0));

      // Fetch address errors around the end of memory.
      reset_dut();
      step("jmp2040", mk(4'h7, 4'h0, 64'd2040, 1, 0, 0, 0, 64'd9, 64'd2040, 3'd1, 32'd1));
      step("irmov2040", mk(4'h3, 4'h0, 0, 0, 0, 0, 0, 64'd2050, 64'd2040, 3'd3, 32'd1));
      reset_dut();
      step("jmp2038", mk(4'h7, 4'h0, 64'd2038, 1, 0, 0, 0, 64'd9, 64'd2038, 3'd1, 32'd1));
      step("irmov2038", mk(4'h3, 4'h0, 0, 0, 0, 0, 0, 64'd2048, 64'd2048, 3'd1, 32'd2));
      step("ins_over_adr", mk(4'hC, 4'h0, 0, 0, 0, 0, 0, 64'd2049, 64'd2048, 3'd4, 32'd2));
      reset_dut();
      step("jmp2047", mk(4'h7, 4'h0, 64'd2047, 1, 0, 0, 0, 64'd9, 64'd2047, 3'd1, 32'd1));
      step("nop2047", mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 64'd2048, 64'd2048, 3'd1, 32'd2));
      step("nop2048", mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 64'd2049, 64'd2048, 3'd3, 32'd2));

      // Data-memory errors, including priority over halt.
      reset_dut();
      step("mrmov_memerr", mk(4'h5, 4'h0, 0, 0, 0, 1, 0, 64'd10, 64'd0, 3'd3, 32'd0));
      reset_dut();
      step("halt_memerr", mk(4'h0, 4'h0, 0, 0, 0, 1, 0, 64'd1, 64'd0, 3'd3, 32'd0));

      // Saturation of the retired counter.
      reset_dut();
      force dut.retired = 32'hFFFF_FFFF;
      #1;
      release dut.retired;
      step("retired_sat", mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 64'd1, 64'd1, 3'd1, 32'hFFFF_FFFF));
      step("retired_sat2", mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 64'd2, 64'd2, 3'd1, 32'hFFFF_FFFF));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, %0d checks so far", n_checks);
      $fatal(1, "timeout");
   end

endmodule
